// File: rtl/mux_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_pkg
// Description : Shared types and constants for the scanning N-to-1 mux.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_scan_pkg;

   // Width of the per-channel dwell programming and its down-counter
   localparam int DWELL_W = 8;

   // Sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : mux_scan_pkg
`default_nettype wire

// File: rtl/mux_scan_n_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_n_if
// Description : Channel data, control and result bundle of mux_scan_n.
//               master = the block driving channels/control,
//               slave  = the mux itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_scan_n_if #(
   parameter int WIDTH    = 1,
   parameter int CHANNELS = 16,
   parameter int SEL_W    = $clog2(CHANNELS)
);
   import mux_scan_pkg::*;

   logic [CHANNELS*WIDTH-1:0] in;
   logic [SEL_W-1:0]          sel;
   logic                      mode;
   logic                      start;
   logic [DWELL_W-1:0]        dwell;
   logic [WIDTH-1:0]          out;
   logic                      out_valid;
   logic [SEL_W-1:0]          cur_sel;
   logic                      busy;
   logic                      done;
   logic                      sel_err;

   modport master (
      output in, sel, mode, start, dwell,
      input  out, out_valid, cur_sel, busy, done, sel_err
   );

   modport slave (
      input  in, sel, mode, start, dwell,
      output out, out_valid, cur_sel, busy, done, sel_err
   );

endinterface : mux_scan_n_if
`default_nettype wire

// File: rtl/mux_n_to_1.sv
`default_nettype none
// ============================================================================
// Module      : mux_n_to_1
// Description : Combinational CHANNELS-to-1 selector of WIDTH-bit words with
//               an out-of-range flag. An out-of-range select yields zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_n_to_1 #(
   parameter int WIDTH    = 1,
   parameter int CHANNELS = 16,
   parameter int SEL_W    = $clog2(CHANNELS)
) (
   input  logic [CHANNELS*WIDTH-1:0] data,
   input  logic [SEL_W-1:0]          sel,
   output logic [WIDTH-1:0]          y,
   output logic                      out_of_range
);

   logic [WIDTH-1:0] w_ch [CHANNELS];

   // Split the packed bus into one word per channel
   for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
      assign w_ch[k] = data[k*WIDTH +: WIDTH];
   end

   // Decode the select; no match means the index names no channel
   always_comb begin
      y            = '0;
      out_of_range = 1'b1;
      for (int k = 0; k < CHANNELS; k++) begin
         if (sel == SEL_W'(k)) begin
            y            = w_ch[k];
            out_of_range = 1'b0;
         end
      end
   end

endmodule : mux_n_to_1
`default_nettype wire

// File: rtl/mux_scan_n.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_n
// Description : N-channel, W-bit registered multiplexer. Direct mode samples
//               the channel named by sel every cycle; scan mode walks all
//               channels once per start pulse with a programmable dwell.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_n
   import mux_scan_pkg::*;
#(
   parameter int WIDTH    = 1,
   parameter int CHANNELS = 16,
   parameter int SEL_W    = $clog2(CHANNELS)
) (
   input  logic         clk,
   input  logic         rst_n,
   mux_scan_n_if.slave  bus
);

   localparam logic [SEL_W-1:0] c_last_chan = SEL_W'(CHANNELS - 1);

   state_t             r_state;
   logic [SEL_W-1:0]   r_chan;
   logic [DWELL_W-1:0] r_dwell_cnt;
   logic [DWELL_W-1:0] r_dwell_lat;
   logic [WIDTH-1:0]   r_out;
   logic               r_out_valid;
   logic [SEL_W-1:0]   r_cur_sel;
   logic               r_busy;
   logic               r_done;
   logic               r_sel_err;

   logic [SEL_W-1:0]   w_mux_sel;
   logic [WIDTH-1:0]   w_mux_data;
   logic               w_mux_oor;

   // The scan counter owns the selector while scanning; sel is never read then
   assign w_mux_sel = (r_state == SCAN) ? r_chan : bus.sel;

   mux_n_to_1 #(
      .WIDTH    (WIDTH),
      .CHANNELS (CHANNELS),
      .SEL_W    (SEL_W)
   ) u_mux (
      .data         (bus.in),
      .sel          (w_mux_sel),
      .y            (w_mux_data),
      .out_of_range (w_mux_oor)
   );

   // Sequencer, counters and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_chan      <= '0;
         r_dwell_cnt <= '0;
         r_dwell_lat <= '0;
         r_out       <= '0;
         r_out_valid <= 1'b0;
         r_cur_sel   <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_sel_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (!bus.mode) begin
                  // Direct: selector already returns zero for a bad index
                  r_out       <= w_mux_data;
                  r_cur_sel   <= bus.sel;
                  r_out_valid <= 1'b1;
                  r_sel_err   <= w_mux_oor;
               end else begin
                  r_out_valid <= 1'b0;
                  r_sel_err   <= 1'b0;
                  if (bus.start) begin
                     r_state     <= SCAN;
                     r_chan      <= '0;
                     r_dwell_cnt <= bus.dwell;
                     r_dwell_lat <= bus.dwell;
                     r_busy      <= 1'b1;
                  end
               end
            end

            SCAN: begin
               r_sel_err <= 1'b0;
               if (r_dwell_cnt != '0) begin
                  r_dwell_cnt <= r_dwell_cnt - 1'b1;
                  r_out_valid <= 1'b0;
               end else begin
                  r_out       <= w_mux_data;
                  r_cur_sel   <= r_chan;
                  r_out_valid <= 1'b1;
                  r_dwell_cnt <= r_dwell_lat;
                  // Counter parks on the last channel rather than wrapping
                  if (r_chan == c_last_chan) begin
                     r_state <= DONE;
                  end else begin
                     r_chan <= r_chan + 1'b1;
                  end
               end
            end

            DONE: begin
               r_done      <= 1'b1;
               r_busy      <= 1'b0;
               r_out_valid <= 1'b0;
               r_state     <= IDLE;
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.out       = r_out;
   assign bus.out_valid = r_out_valid;
   assign bus.cur_sel   = r_cur_sel;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.sel_err   = r_sel_err;

endmodule : mux_scan_n
`default_nettype wire

// File: tb/tb_mux_scan_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan_n
// Description : Self-checking bench for mux_scan_n. A 16x1 instance exercises
//               direct and scan modes; a 10x4 instance exercises the
//               out-of-range select on a non-power-of-two channel count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan_n;

   logic clk;
   logic rst_n;

   int n_vec;
   int n_err;

   mux_scan_n_if #(.WIDTH(1), .CHANNELS(16)) bus16 ();
   mux_scan_n_if #(.WIDTH(4), .CHANNELS(10)) bus10 ();

   mux_scan_n #(.WIDTH(1), .CHANNELS(16)) dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus16)
   );

   mux_scan_n #(.WIDTH(4), .CHANNELS(10)) dut10 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus10)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // ------------------------------------------------------------------
   // Behavioural model, 16x1 instance: each accepted start defines a
   // timeline; sample k lands (k+1)(d+1) edges after it, done one edge
   // after the last sample.
   // ------------------------------------------------------------------
   int         cyc;
   int         m_e0;
   int         m_d;
   bit         m_act;
   logic       m_out;
   logic       m_valid;
   logic [3:0] m_cur;
   logic       m_busy;
   logic       m_done;
   logic       m_err;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc <= 0; m_e0 <= 0; m_d <= 0; m_act <= 1'b0;
         m_out <= 1'b0; m_valid <= 1'b0; m_cur <= 4'd0;
         m_busy <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
      end else begin
         cyc <= cyc + 1;
         if (m_act && (cyc - m_e0) <= 16*(m_d+1) + 1) begin
            m_err <= 1'b0;
            if ((cyc - m_e0) <= 16*(m_d+1)) begin
               m_busy <= 1'b1;
               m_done <= 1'b0;
               if ((cyc - m_e0) % (m_d+1) == 0) begin
                  m_out   <= bus16.in[(cyc - m_e0)/(m_d+1) - 1];
                  m_cur   <= 4'((cyc - m_e0)/(m_d+1) - 1);
                  m_valid <= 1'b1;
               end else begin
                  m_valid <= 1'b0;
               end
            end else begin
               m_done  <= 1'b1;
               m_busy  <= 1'b0;
               m_valid <= 1'b0;
               m_act   <= 1'b0;
            end
         end else begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
            m_err  <= 1'b0;
            if (!bus16.mode) begin
               m_out   <= bus16.in[bus16.sel];
               m_cur   <= bus16.sel;
               m_valid <= 1'b1;
            end else begin
               m_valid <= 1'b0;
               if (bus16.start) begin
                  m_act  <= 1'b1;
                  m_e0   <= cyc;
                  m_d    <= int'(bus16.dwell);
                  m_busy <= 1'b1;
               end
            end
         end
      end
   end

   // Model, 10x4 instance (direct mode only)
   logic [3:0] m10_out;
   logic [3:0] m10_cur;
   logic       m10_valid;
   logic       m10_err;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m10_out <= 4'h0; m10_cur <= 4'h0; m10_valid <= 1'b0; m10_err <= 1'b0;
      end else begin
         m10_out   <= (bus10.sel < 4'd10) ? bus10.in[bus10.sel*4 +: 4] : 4'h0;
         m10_cur   <= bus10.sel;
         m10_valid <= 1'b1;
         m10_err   <= (bus10.sel >= 4'd10);
      end
   end

   // Every-cycle comparison against the models
   always @(posedge clk) begin
      #2;
      chk("m16.out",       {31'd0, bus16.out},       {31'd0, m_out});
      chk("m16.out_valid", {31'd0, bus16.out_valid}, {31'd0, m_valid});
      chk("m16.cur_sel",   {28'd0, bus16.cur_sel},   {28'd0, m_cur});
      chk("m16.busy",      {31'd0, bus16.busy},      {31'd0, m_busy});
      chk("m16.done",      {31'd0, bus16.done},      {31'd0, m_done});
      chk("m16.sel_err",   {31'd0, bus16.sel_err},   {31'd0, m_err});
      chk("m10.out",       {28'd0, bus10.out},       {28'd0, m10_out});
      chk("m10.cur_sel",   {28'd0, bus10.cur_sel},   {28'd0, m10_cur});
      chk("m10.out_valid", {31'd0, bus10.out_valid}, {31'd0, m10_valid});
      chk("m10.sel_err",   {31'd0, bus10.sel_err},   {31'd0, m10_err});
   end

   // ------------------------------------------------------------------
   // Directed stimulus with hand-computed literal expectations
   // ------------------------------------------------------------------
   int pat   [16] = '{1,1,0,1,0,1,0,1,0,0,0,0,1,1,0,0};
   int dsel  [4]  = '{3,0,2,4};
   int dexp  [4]  = '{1,1,0,0};
   int s10   [5]  = '{12,9,0,10,5};
   int e10   [5]  = '{0,10,1,0,6};
   int err10 [5]  = '{1,0,0,1,0};

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus16.in = 16'h30ab; bus16.sel = '0; bus16.mode = 1'b0;
      bus16.start = 1'b0;  bus16.dwell = 8'd0;
      bus10.in = 40'hA987654321; bus10.sel = '0; bus10.mode = 1'b0;
      bus10.start = 1'b0;  bus10.dwell = 8'd0;

      #13;
      chk("rst.out",       {31'd0, bus16.out},       32'd0);
      chk("rst.out_valid", {31'd0, bus16.out_valid}, 32'd0);
      chk("rst.busy",      {31'd0, bus16.busy},      32'd0);
      chk("rst.sel_err10", {31'd0, bus10.sel_err},   32'd0);
      #9 rst_n = 1'b1;
      step();

      // Direct mode on both instances
      for (int i = 0; i < 5; i++) begin
         if (i < 4) bus16.sel = 4'(dsel[i]);
         bus10.sel = 4'(s10[i]);
         step();
         if (i < 4) begin
            chk("dir16.out",       {31'd0, bus16.out},       32'(dexp[i]));
            chk("dir16.out_valid", {31'd0, bus16.out_valid}, 32'd1);
            chk("dir16.sel_err",   {31'd0, bus16.sel_err},   32'd0);
         end
         chk("dir10.out",     {28'd0, bus10.out},     32'(e10[i]));
         chk("dir10.sel_err", {31'd0, bus10.sel_err}, 32'(err10[i]));
      end

      // start while in direct mode is ignored
      bus16.start = 1'b1;
      step();
      bus16.start = 1'b0;
      chk("dirstart.busy", {31'd0, bus16.busy}, 32'd0);
      step();
      chk("dirstart.busy2", {31'd0, bus16.busy}, 32'd0);

      // Scan, dwell = 0
      bus16.mode = 1'b1; bus16.dwell = 8'd0; bus16.start = 1'b1;
      step();                                   // E0
      bus16.start = 1'b0;
      chk("scan0.busy", {31'd0, bus16.busy}, 32'd1);
      for (int k = 0; k < 16; k++) begin
         step();
         chk("scan0.valid", {31'd0, bus16.out_valid}, 32'd1);
         chk("scan0.out",   {31'd0, bus16.out},       32'(pat[k]));
         chk("scan0.cur",   {28'd0, bus16.cur_sel},   32'(k));
      end
      step();
      chk("scan0.done", {31'd0, bus16.done}, 32'd1);
      chk("scan0.busy_end", {31'd0, bus16.busy}, 32'd0);
      chk("scan0.out_hold", {31'd0, bus16.out}, 32'd0);
      step();
      chk("scan0.done_pulse", {31'd0, bus16.done}, 32'd0);

      // Scan, dwell = 2, with ignored start/mode/dwell disturbances
      bus16.dwell = 8'd2; bus16.start = 1'b1;
      step();                                   // E0
      bus16.start = 1'b0;
      for (int t = 1; t <= 50; t++) begin
         step();
         chk("scan2.valid", {31'd0, bus16.out_valid},
             (t % 3 == 0 && t <= 48) ? 32'd1 : 32'd0);
         chk("scan2.done", {31'd0, bus16.done}, (t == 49) ? 32'd1 : 32'd0);
         if (t % 3 == 0 && t <= 48)
            chk("scan2.cur", {28'd0, bus16.cur_sel}, 32'(t/3 - 1));
         if (t == 9)  begin bus16.start = 1'b1; bus16.mode = 1'b0; end
         if (t == 10) begin bus16.start = 1'b0; bus16.mode = 1'b1; end
         if (t == 20) bus16.dwell = 8'd5;
      end

      // Reset during channel 7 of a dwell-0 scan
      bus16.dwell = 8'd0; bus16.start = 1'b1;
      step();                                   // E0
      bus16.start = 1'b0;
      for (int k = 0; k < 8; k++) step();
      chk("mid.cur_before", {28'd0, bus16.cur_sel}, 32'd7);
      #1 rst_n = 1'b0;
      #1;
      chk("mid.out",   {31'd0, bus16.out},       32'd0);
      chk("mid.cur",   {28'd0, bus16.cur_sel},   32'd0);
      chk("mid.valid", {31'd0, bus16.out_valid}, 32'd0);
      chk("mid.busy",  {31'd0, bus16.busy},      32'd0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("mid.no_done", {31'd0, bus16.done}, 32'd0);
      end
      #1 rst_n = 1'b1;
      step();
      bus16.start = 1'b1;
      step();                                   // new E0
      bus16.start = 1'b0;
      step();
      chk("rescan.valid", {31'd0, bus16.out_valid}, 32'd1);
      chk("rescan.cur",   {28'd0, bus16.cur_sel},   32'd0);
      chk("rescan.out",   {31'd0, bus16.out},       32'd1);
      for (int k = 0; k < 18; k++) step();
      chk("rescan.idle", {31'd0, bus16.busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_mux_scan_n
`default_nettype wire

// File: doc/mux_scan_n.md
# mux_scan_n

Parametrised N-channel, W-bit registered multiplexer with an autonomous scan sequencer. It replaces the fixed combinational 16-to-1 bit mux in designs that need wider data, arbitrary channel counts, a registered output, or hands-free sequencing. In direct mode it samples the channel named by `sel` every cycle. In scan mode a single `start` pulse walks through every channel in order, holding each for a programmable dwell, and reports each sample with a valid strobe.

## Interface

Parameters:
- `WIDTH`, default 1: bits per channel.
- `CHANNELS`, default 16: number of input channels, 2..256. Need not be a power of two.
- `SEL_W`, default `$clog2(CHANNELS)`: select width. Derived; do not override.

Ports:
- `clk`  in  1  clock. Single clock domain; all logic updates on the rising edge.
- `rst_n`  in  1  reset. Asynchronous, active-low.
- `in`  in  `CHANNELS*WIDTH`  packed channel data; channel k occupies `in[k*WIDTH +: WIDTH]`.
- `sel`  in  `SEL_W`  channel select, used in direct mode only.
- `mode`  in  1  0 = direct, 1 = scan.
- `start`  in  1  scan trigger, one-cycle pulse; level-tolerant.
- `dwell`  in  8  extra cycles per channel in scan; latched at start.
- `out`  out  `WIDTH`  registered selected channel data.
- `out_valid`  out  1  `out` updated this cycle.
- `cur_sel`  out  `SEL_W`  channel index that produced `out`.
- `busy`  out  1  scan in progress.
- `done`  out  1  one-cycle pulse at scan completion.
- `sel_err`  out  1  direct-mode `sel >= CHANNELS`.

## Operation

- Reset, asynchronous on `rst_n` low: `out=0`, `out_valid=0`, `cur_sel=0`, `busy=0`, `done=0`, `sel_err=0`. State becomes IDLE; the channel counter and dwell counter are cleared.
- States: IDLE, SCAN, DONE.
- IDLE with `mode=0` (direct):
  - Each edge: `out<=ch[sel]`, `cur_sel<=sel`, `out_valid<=1`, `sel_err<=0`.
  - If `sel>=CHANNELS`: `out<=0`, `sel_err<=1`, `out_valid<=1`.
- IDLE with `mode=1`:
  - `out` and `cur_sel` hold; `out_valid<=0`; `sel_err<=0`.
  - `start=1` sampled on an edge → SCAN. On that edge: channel counter `<=0`, dwell counter `<=dwell`, `busy<=1`.
- SCAN:
  - Each edge with dwell counter ≠ 0: decrement; `out_valid<=0`.
  - Each edge with dwell counter = 0: `out<=ch[chan]`, `cur_sel<=chan`, `out_valid<=1`, dwell counter reloaded from the latched dwell.
  - If `chan==CHANNELS-1` on that edge: → DONE. Otherwise `chan<=chan+1`.
- DONE, one cycle: `done<=1`, `busy<=0`, `out_valid<=0`, then → IDLE. `out` holds the last channel sample.
- Ignored conditions:
  - `start` while in SCAN or DONE.
  - `start` while `mode=0`.
  - Changes to `mode`, `sel` or `dwell` during SCAN; the scan always completes all channels.
- Scan mode never reads `sel`. The channel counter never exceeds `CHANNELS-1`, so scan never produces `sel_err`.
- Arithmetic:
  - The channel counter is `SEL_W` bits and stops at `CHANNELS-1`; it does not wrap.
  - The dwell counter is 8 bits and counts down from the latched value.

## Timing

- Direct mode: 1-cycle latency, `sel`/`in` at edge N → `out` after edge N. Throughput is 1 sample/cycle.
- Scan:
  - Start sampled at edge E0.
  - Sample k appears after edge E0+(k+1)(dwell+1).
  - `done` is high for the cycle after edge E0+CHANNELS(dwell+1)+1.
  - `busy` is high from after E0 until `done` rises.
- `out_valid` in scan is a single-cycle pulse per channel. With `dwell=0` it is high for CHANNELS consecutive cycles.
- Back-to-back scans: `start` may be accepted on the edge that leaves DONE→IDLE only on the following edge. Minimum gap is 1 idle cycle after `done`.
- Reset mid-scan aborts immediately: `done` is not pulsed and outputs return to their reset values asynchronously.

## Structure

- Shared package `mux_scan_pkg`:
  - State encoding constants: IDLE=2'd0, SCAN=2'd1, DONE=2'd2.
  - `DWELL_W=8`.
- Sub-module `mux_n_to_1`: purely combinational WIDTH×CHANNELS selector with an out-of-range flag. It is instantiated once, fed by a mux of `sel` and the channel counter.
- Top level contains the FSM, counters and output registers only.

## Test plan

- Direct mode, WIDTH=1, CHANNELS=16, `in=16'h30ab`, `mode=0`: sel sequence 3,0,2,4 → `out` after one edge = 1,1,0,0. `out_valid` stays 1 and `sel_err` stays 0.
- Scan with dwell=0, `in=16'h30ab`, start pulse:
  - 16 consecutive `out_valid` cycles.
  - `out` = 1,1,0,1,0,1,0,1,0,0,0,0,1,1,0,0.
  - `cur_sel` = 0..15.
  - `done` is high one cycle after the 16th sample.
- Scan with dwell=2: samples after edges E0+3, +6, …, +48; `done` after E0+49. A `start` pulse and a `mode` toggle at E0+10 have no effect.
- CHANNELS=10, WIDTH=4, direct mode: `sel=12` → `out=4'h0`, `sel_err=1`. `sel=9` → `out=ch9`, `sel_err=0`.
- Reset mid-scan: `rst_n` low during channel 7 → all outputs 0 with no clock edge, state IDLE, no `done`. A new start after release scans from channel 0.
- `start` with `mode=0` → stays in direct mode, `busy` stays 0.
